reversible_inverse_unit: RTL and testbench

Streaming inverse-gate unit that recovers the original operands (A, B, C) from 32-bit bitwise Fredkin, Peres or Toffoli gate outputs (P, Q, R). It is the decode side of the reversible ALU datapath: ALU result words enter on a valid/ready stream, and recovered operands leave through a small output FIFO. It lets the reversible ALU be verified, or run backwards, in-system.

---
 rtl/reversible_inverse_unit.sv | 136 +++++++++++++
 tb/tb_reversible_inverse_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/reversible_inverse_unit.sv
// Inverse Fredkin/Peres/Toffoli decoder: one stage register feeding a small output FIFO.
// Optional op_count output is enabled with the REV_OPCOUNT_EN macro.
module reversible_inverse_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_p,
  input  logic [WIDTH-1:0] in_q,
  input  logic [WIDTH-1:0] in_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic             out_err
`ifdef REV_OPCOUNT_EN
  ,
  output logic [31:0]      op_count
`endif
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = 3 * WIDTH + 1;

  typedef enum logic [1:0] {OpFredkin = 2'b00, OpPeres = 2'b01, OpToffoli = 2'b10,
                            OpIllegal = 2'b11} op_e;

  op_e              s_op_q;
  logic [WIDTH-1:0] s_p_q, s_q_q, s_r_q;
  logic             s_valid_q;
  logic             in_fire;

  logic [WIDTH-1:0] dec_a, dec_b, dec_c;
  logic             dec_err;

  logic [EntW-1:0]  mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [CntW:0]    occupancy;
  logic             push, pop;
  logic [EntW-1:0]  head;

  assign in_fire = in_valid && in_ready;

  // Stage always drains on the next edge; in_ready already reserves its FIFO slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid_q <= 1'b0;
      s_op_q    <= OpFredkin;
      s_p_q     <= '0;
      s_q_q     <= '0;
      s_r_q     <= '0;
    end else begin
      s_valid_q <= in_fire;
      if (in_fire) begin
        s_op_q <= op_e'(in_op);
        s_p_q  <= in_p;
        s_q_q  <= in_q;
        s_r_q  <= in_r;
      end
    end
  end

  always_comb begin
    dec_a   = s_p_q;
    dec_b   = s_q_q;
    dec_c   = s_r_q;
    dec_err = 1'b0;
    unique case (s_op_q)
      OpFredkin: begin
        dec_b = (s_p_q & s_r_q) | (~s_p_q & s_q_q);
        dec_c = (s_p_q & s_q_q) | (~s_p_q & s_r_q);
      end
      OpPeres: begin
        dec_b = s_p_q ^ s_q_q;
        dec_c = s_r_q ^ (s_p_q & (s_p_q ^ s_q_q));
      end
      OpToffoli: begin
        dec_c = s_r_q ^ (s_p_q & s_q_q);
      end
      OpIllegal: begin
        dec_a   = '0;
        dec_b   = '0;
        dec_c   = '0;
        dec_err = 1'b1;
      end
    endcase
  end

  assign push = s_valid_q;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {dec_a, dec_b, dec_c, dec_err};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign occupancy = {1'b0, count_q} + (CntW + 1)'(s_valid_q);
  assign in_ready  = occupancy < (CntW + 1)'(FIFO_DEPTH);
  assign out_valid = count_q != '0;
  assign head      = out_valid ? mem_q[rd_ptr_q] : '0;
  assign {out_a, out_b, out_c, out_err} = head;

`ifdef REV_OPCOUNT_EN
  logic [31:0] op_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   op_count_q <= '0;
    else if (pop) op_count_q <= op_count_q + 32'd1;
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_reversible_inverse_unit.sv
// Directed bench for reversible_inverse_unit plus a forward-gate random stream.
// Checks op_count as well when REV_OPCOUNT_EN is defined.
module tb_reversible_inverse_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_p, in_q, in_r;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a, out_b, out_c;
  logic        out_err;
`ifdef REV_OPCOUNT_EN
  logic [31:0] op_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [95:0] exp_q[$];

  always #5 clk = ~clk;

  reversible_inverse_unit #(.WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_p      (in_p),
    .in_q      (in_q),
    .in_r      (in_r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_err   (out_err)
`ifdef REV_OPCOUNT_EN
    ,
    .op_count  (op_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic send(input string tag, input logic [1:0] op, input logic [31:0] p,
                      input logic [31:0] q, input logic [31:0] r);
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    check_eq({tag, "_rdy"}, in_ready, 1);
    in_valid = 1'b1;
    in_op    = op;
    in_p     = p;
    in_q     = q;
    in_r     = r;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_pop(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic err);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check_eq({tag, "_vld"}, out_valid, 1);
    check_eq(tag, {out_a, out_b, out_c, out_err}, {a, b, c, err});
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Peres vector with exact 2-cycle latency check, then pop and confirm it was alone.
  task automatic peres_latency(input string tag);
    in_valid = 1'b1;
    in_op    = 2'b01;
    in_p     = 32'hFFFF0000;
    in_q     = 32'hF0F00F0F;
    in_r     = 32'h0FF000FF;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq({tag, "_lat1"}, out_valid, 0);
    @(negedge clk);
    check_eq({tag, "_lat2"}, out_valid, 1);
    expect_pop(tag, 32'hFFFF0000, 32'h0F0F0F0F, 32'h00FF00FF, 1'b0);
    check_eq({tag, "_alone"}, out_valid, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_p      = '0;
    in_q      = '0;
    in_r      = '0;
    out_ready = 1'b0;
    @(negedge clk);
    check_eq("rst_vld_in_reset", out_valid, 0);
    do_reset();

    check_eq("rst_ready", in_ready, 1);
    check_eq("rst_vld", out_valid, 0);
    check_eq("rst_data", {out_a, out_b, out_c, out_err}, 0);
`ifdef REV_OPCOUNT_EN
    check_eq("rst_opcnt", op_count, 0);
`endif

    peres_latency("peres");

    send("fred", 2'b00, 32'hFFFF0000, 32'h12345678, 32'h9ABCDEF0);
    expect_pop("fred", 32'hFFFF0000, 32'h9ABC5678, 32'h1234DEF0, 1'b0);
    send("toff", 2'b10, 32'hFFFF0000, 32'h12345678, 32'h9ABCDEF0);
    expect_pop("toff", 32'hFFFF0000, 32'h12345678, 32'h8888DEF0, 1'b0);

    // Backpressure: P=0 Toffoli words pass Q/R straight through.
    for (int i = 0; i < 4; i++)
      send("bp_in", 2'b10, 32'h0, 32'h1000 + i, 32'hA000 + i);
    check_eq("bp_full", in_ready, 0);
    expect_pop("bp_out0", 32'h0, 32'h1000, 32'hA000, 1'b0);
    check_eq("bp_reopen", in_ready, 1);
    send("bp_in4", 2'b10, 32'h0, 32'h1004, 32'hA004);
    expect_pop("bp_out1", 32'h0, 32'h1001, 32'hA001, 1'b0);
    send("bp_in5", 2'b10, 32'h0, 32'h1005, 32'hA005);
    for (int i = 2; i < 6; i++)
      expect_pop("bp_out", 32'h0, 32'h1000 + i, 32'hA000 + i, 1'b0);
    check_eq("bp_empty", out_valid, 0);

    send("ill", 2'b11, 32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678);
    send("post_ill", 2'b00, 32'h0000FFFF, 32'hAAAAAAAA, 32'h55555555);
    expect_pop("ill", 32'h0, 32'h0, 32'h0, 1'b1);
    expect_pop("post_ill", 32'h0000FFFF, 32'hAAAA5555, 32'h5555AAAA, 1'b0);

    // Reset with three words queued, asserted away from any clock edge.
    for (int i = 0; i < 3; i++)
      send("mid_in", 2'b10, 32'h0, 32'h2000 + i, 32'hB000 + i);
    @(negedge clk);
    check_eq("mid_queued", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_vld", out_valid, 0);
    check_eq("mid_rst_data", {out_a, out_b, out_c, out_err}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("mid_post_vld", out_valid, 0);
    check_eq("mid_post_rdy", in_ready, 1);
`ifdef REV_OPCOUNT_EN
    check_eq("mid_opcnt", op_count, 0);
`endif
    peres_latency("mid_peres");

    // Random stream of forward-gate words with random out_ready.
    do_reset();
    exp_q.delete();
    fork
      begin : producer
        for (int n = 0; n < 1000; n++) begin
          logic [31:0] a, b, c, p, q, r;
          logic [1:0]  op;
          a  = $urandom;
          b  = $urandom;
          c  = $urandom;
          op = 2'($urandom_range(0, 2));
          p  = a;
          unique case (op)
            2'b00: begin q = (a & c) | (~a & b); r = (a & b) | (~a & c); end
            2'b01: begin q = a ^ b; r = (a & b) ^ c; end
            default: begin q = b; r = c ^ (a & b); end
          endcase
          in_valid = 1'b1;
          in_op    = op;
          in_p     = p;
          in_q     = q;
          in_r     = r;
          for (int w = 0; w < 200 && !in_ready; w++) @(negedge clk);
          if (!in_ready) check_eq("rnd_in_stall", in_ready, 1);
          @(posedge clk);
          exp_q.push_back({a, b, c});
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin : consumer
        int rcvd = 0;
        for (int cyc = 0; cyc < 30000 && rcvd < 1000; cyc++) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              check_eq("rnd_extra", out_valid, 0);
            end else begin
              check_eq("rnd", {out_a, out_b, out_c, out_err}, {exp_q.pop_front(), 1'b0});
            end
            rcvd++;
          end
        end
        check_eq("rnd_count", rcvd, 1000);
      end
    join
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    check_eq("rnd_drained", out_valid, 0);
`ifdef REV_OPCOUNT_EN
    check_eq("rnd_opcnt", op_count, 1000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
